// File: rtl/tdr_pkg.sv
// Shared types and constants for the TDR cell controller.
package tdr_pkg;

    // Controller sequencing states.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_WE0,
        ST_GAP,
        ST_WE1,
        ST_RD_WAIT
    } tdr_state_t;

    // Cycles of latency added by the two-flop synchronizer on the TDR outputs.
    localparam int SYNC_LAT = 2;

    // Bits needed to hold any value in 0..max_val (never less than one).
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tdr_sync2.sv
// Two-flop synchronizer bringing an asynchronous TDR signal into clk_i.
module tdr_sync2 (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic r_meta;
    logic r_sync;

    // First flop may go metastable; second flop gives it a full cycle to settle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make both flops sample the old
            // values, giving a true two-stage chain rather than one flop.
            r_meta <= d_i;
            r_sync <= r_meta;
        end
    end

    assign q_o = r_sync;

endmodule

// File: rtl/tdr_controller.sv
// Sequencer for one time-domain register cell: encodes writes as WE0->WE1
// pulse spacing and decodes reads by timing the cell's output rising edge.
module tdr_controller
    import tdr_pkg::*;
#(
    parameter int VAL_W     = 4,
    parameter int PULSE_W   = 2,
    parameter int RD_OFFSET = 2,
    parameter int TIMEOUT   = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_req_i,
    input  logic [VAL_W-1:0] wr_data_i,
    input  logic             rd_req_i,
    output logic             ready_o,
    output logic             wr_done_o,
    output logic             rd_valid_o,
    output logic [VAL_W-1:0] rd_data_o,
    output logic             rd_err_o,
    output logic             rd_carry_o,
    output logic             tdr_we0_o,
    output logic             tdr_we1_o,
    output logic             tdr_re_o,
    output logic             tdr_rstb_o,
    input  logic             tdr_out_i,
    input  logic             tdr_carry_i
);

    // One counter serves pulse widths, the gap and the read timer; the read
    // timer dominates because TIMEOUT exceeds the largest encodable value.
    localparam int CNT_W = max_int(cnt_width(TIMEOUT),
                                   max_int(cnt_width(2**VAL_W), cnt_width(PULSE_W)));

    localparam logic [CNT_W-1:0] PW_LAST  = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] DEC_BIAS = CNT_W'(SYNC_LAT + RD_OFFSET);
    localparam logic [CNT_W-1:0] MAX_VAL  = CNT_W'((2**VAL_W) - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    tdr_state_t       r_state;
    tdr_state_t       w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [VAL_W-1:0] r_val;
    logic [VAL_W-1:0] r_rd_data;
    logic             r_rd_err;
    logic             r_rd_carry;
    logic             r_wr_done;
    logic             r_rd_valid;
    logic             r_we0;
    logic             r_we1;
    logic             r_re;
    logic             r_rstb;
    logic             r_out_prev;

    logic             w_out_s;
    logic             w_carry_s;
    logic             w_out_rise;
    logic [CNT_W-1:0] w_val_ext;
    logic [CNT_W-1:0] w_diff;
    logic [VAL_W-1:0] w_dec_data;
    logic             w_dec_err;
    logic             w_capture_wr;
    logic             w_wr_done;
    logic             w_rd_done;
    logic [VAL_W-1:0] w_rd_data;
    logic             w_rd_err;
    logic             w_carry_cap;

    tdr_sync2 u_sync_out (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (tdr_out_i),
        .q_o   (w_out_s)
    );

    tdr_sync2 u_sync_carry (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (tdr_carry_i),
        .q_o   (w_carry_s)
    );

    assign w_out_rise = w_out_s & ~r_out_prev;
    assign w_val_ext  = CNT_W'(r_val);
    assign w_diff     = r_cnt - DEC_BIAS;

    // Convert the edge count into a value, clamping out-of-range results.
    always_comb begin
        w_dec_data = '0;
        w_dec_err  = 1'b1;
        if (r_cnt < DEC_BIAS) begin
            w_dec_data = '0;
            w_dec_err  = 1'b1;
        end else if (w_diff > MAX_VAL) begin
            w_dec_data = '1;
            w_dec_err  = 1'b1;
        end else begin
            w_dec_data = w_diff[VAL_W-1:0];
            w_dec_err  = 1'b0;
        end
    end

    // Next-state and completion decode.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves one unassigned, which would otherwise infer a latch.
        w_next_state = r_state;
        w_capture_wr = 1'b0;
        w_wr_done    = 1'b0;
        w_rd_done    = 1'b0;
        w_rd_data    = '0;
        w_rd_err     = 1'b0;
        w_carry_cap  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (wr_req_i) begin
                    w_capture_wr = 1'b1;
                    w_next_state = ST_CLEAR;
                end else if (rd_req_i) begin
                    w_next_state = ST_RD_WAIT;
                end
            end
            ST_CLEAR: begin
                w_next_state = ST_WE0;
            end
            ST_WE0: begin
                if (r_cnt == PW_LAST) begin
                    w_next_state = (r_val == '0) ? ST_WE1 : ST_GAP;
                end
            end
            ST_GAP: begin
                if (r_cnt + CNT_ONE == w_val_ext) begin
                    w_next_state = ST_WE1;
                end
            end
            ST_WE1: begin
                if (r_cnt == PW_LAST) begin
                    w_wr_done    = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            ST_RD_WAIT: begin
                if (r_cnt == '0 && w_out_s) begin
                    // Output was already high when the read began: stale cell.
                    w_rd_done    = 1'b1;
                    w_rd_err     = 1'b1;
                    w_next_state = ST_IDLE;
                end else if (w_out_rise) begin
                    w_rd_done    = 1'b1;
                    w_rd_data    = w_dec_data;
                    w_rd_err     = w_dec_err;
                    w_carry_cap  = 1'b1;
                    w_next_state = ST_IDLE;
                end else if (r_cnt == TO_LAST) begin
                    w_rd_done    = 1'b1;
                    w_rd_err     = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Phase counter restarts on every state change, value capture and read results.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt      <= '0;
            r_val      <= '0;
            r_rd_data  <= '0;
            r_rd_err   <= 1'b0;
            r_rd_carry <= 1'b0;
            r_out_prev <= 1'b0;
        end else begin
            r_out_prev <= w_out_s;
            if (w_next_state != r_state) begin
                r_cnt <= '0;
            end else if (r_state != ST_IDLE) begin
                r_cnt <= r_cnt + CNT_ONE;
            end
            if (w_capture_wr) begin
                r_val <= wr_data_i;
            end
            if (w_rd_done) begin
                r_rd_data <= w_rd_data;
                r_rd_err  <= w_rd_err;
            end
            if (w_carry_cap) begin
                r_rd_carry <= w_carry_s;
            end
        end
    end

    // Registered strobes to the cell and pulses to the host, glitch-free.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_we0      <= 1'b0;
            r_we1      <= 1'b0;
            r_re       <= 1'b0;
            r_rstb     <= 1'b0;
            r_wr_done  <= 1'b0;
            r_rd_valid <= 1'b0;
        end else begin
            r_we0      <= (w_next_state == ST_WE0);
            r_we1      <= (w_next_state == ST_WE1);
            r_re       <= (w_next_state == ST_RD_WAIT);
            r_rstb     <= (w_next_state != ST_CLEAR);
            r_wr_done  <= w_wr_done;
            r_rd_valid <= w_rd_done;
        end
    end

    assign ready_o    = (r_state == ST_IDLE);
    assign wr_done_o  = r_wr_done;
    assign rd_valid_o = r_rd_valid;
    assign rd_data_o  = r_rd_data;
    assign rd_err_o   = r_rd_err;
    assign rd_carry_o = r_rd_carry;
    assign tdr_we0_o  = r_we0;
    assign tdr_we1_o  = r_we1;
    assign tdr_re_o   = r_re;
    assign tdr_rstb_o = r_rstb;

endmodule

// File: tb/tb_tdr_controller.sv
// Scoreboard bench for tdr_controller: drivers push expected completions,
// a negedge monitor pops and compares them when wr_done_o/rd_valid_o fire.
module tb_tdr_controller;

    localparam int VAL_W   = 4;
    localparam int PULSE_W = 2;
    localparam int TIMEOUT = 64;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b1;
    logic             wr_req_i = 1'b0;
    logic [VAL_W-1:0] wr_data_i = '0;
    logic             rd_req_i = 1'b0;
    logic             ready_o;
    logic             wr_done_o;
    logic             rd_valid_o;
    logic [VAL_W-1:0] rd_data_o;
    logic             rd_err_o;
    logic             rd_carry_o;
    logic             tdr_we0_o;
    logic             tdr_we1_o;
    logic             tdr_re_o;
    logic             tdr_rstb_o;
    logic             tdr_out_i = 1'b0;
    logic             tdr_carry_i = 1'b0;

    tdr_controller #(
        .VAL_W     (VAL_W),
        .PULSE_W   (PULSE_W),
        .RD_OFFSET (2),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .wr_req_i    (wr_req_i),
        .wr_data_i   (wr_data_i),
        .rd_req_i    (rd_req_i),
        .ready_o     (ready_o),
        .wr_done_o   (wr_done_o),
        .rd_valid_o  (rd_valid_o),
        .rd_data_o   (rd_data_o),
        .rd_err_o    (rd_err_o),
        .rd_carry_o  (rd_carry_o),
        .tdr_we0_o   (tdr_we0_o),
        .tdr_we1_o   (tdr_we1_o),
        .tdr_re_o    (tdr_re_o),
        .tdr_rstb_o  (tdr_rstb_o),
        .tdr_out_i   (tdr_out_i),
        .tdr_carry_i (tdr_carry_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit         is_wr;
        int         acc;
        int         lat;
        int         v;
        logic [3:0] data;
        bit         err;
        bit         carry;
        bit         chk_carry;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk_i) cyc++;

    // Monitor: tracks strobe edges and busy time, scores each completion.
    int   we0_rise, we1_rise, rstb_fall, busy;
    logic p_we0, p_we1, p_rstb;
    exp_t m_e;
    always @(negedge clk_i) begin
        if (rst_i) begin
            p_we0 = 1'b0; p_we1 = 1'b0; p_rstb = 1'b0; busy = 0;
        end else begin
            if (tdr_we0_o || tdr_we1_o) check("we_overlap", 32'(tdr_we0_o & tdr_we1_o), 0);
            if (tdr_we0_o && !p_we0) we0_rise = cyc;
            if (tdr_we1_o && !p_we1) we1_rise = cyc;
            if (!tdr_rstb_o && p_rstb) rstb_fall = cyc;
            if (!ready_o) busy++;
            if (wr_done_o || rd_valid_o) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_completion: wr_done=%0b rd_valid=%0b required none (cycle %0d)",
                             wr_done_o, rd_valid_o, cyc);
                end else begin
                    m_e = q.pop_front();
                    check("kind_wr", 32'(wr_done_o), 32'(m_e.is_wr));
                    check("latency", cyc - m_e.acc, m_e.lat);
                    check("busy_cycles", busy, m_e.lat - 1);
                    check("ready_at_done", 32'(ready_o), 1);
                    check("re_low_at_done", 32'(tdr_re_o), 0);
                    if (m_e.is_wr) begin
                        check("rstb_low_cycle", rstb_fall - m_e.acc, 1);
                        check("we0_rise_cycle", we0_rise - m_e.acc, 2);
                        check("we_spacing", we1_rise - we0_rise, PULSE_W + m_e.v);
                    end else begin
                        check("rd_data", 32'(rd_data_o), 32'(m_e.data));
                        check("rd_err", 32'(rd_err_o), 32'(m_e.err));
                        if (m_e.chk_carry) check("rd_carry", 32'(rd_carry_o), 32'(m_e.carry));
                    end
                end
                busy = 0;
            end
            p_we0 = tdr_we0_o; p_we1 = tdr_we1_o; p_rstb = tdr_rstb_o;
        end
    end

    task automatic wait_done();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_i);
            if (q.size() == 0) break;
        end
        if (q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL completion_timeout: %0d pending, required 0", q.size());
            q.delete();
        end
        repeat (3) @(negedge clk_i);
    endtask

    task automatic do_write(input int v, input bit with_rd, input bit expect_done);
        exp_t e;
        e.is_wr = 1'b1; e.v = v; e.lat = 2 + 2 * PULSE_W + v;
        e.data = '0; e.err = 1'b0; e.carry = 1'b0; e.chk_carry = 1'b0;
        check("ready_before_wr", 32'(ready_o), 1);
        e.acc = cyc;
        if (expect_done) q.push_back(e);
        wr_req_i = 1'b1; wr_data_i = VAL_W'(v); rd_req_i = with_rd;
        @(negedge clk_i);
        wr_req_i = 1'b0; rd_req_i = 1'b0;
        if (expect_done) wait_done();
    endtask

    // mode 0: edge at count c; mode 1: output held low; mode 2: stale output.
    task automatic do_read(input int c, input bit carry, input int mode);
        exp_t e;
        int   d;
        e.is_wr = 1'b0; e.v = 0; e.carry = carry; e.chk_carry = (mode == 0);
        if (mode == 0) begin
            d = c - 4;
            e.lat = 2 + c;
            if (d < 0) begin e.data = 4'd0; e.err = 1'b1; end
            else if (d > 15) begin e.data = 4'd15; e.err = 1'b1; end
            else begin e.data = 4'(d); e.err = 1'b0; end
        end else if (mode == 1) begin
            e.lat = TIMEOUT + 1; e.data = 4'd0; e.err = 1'b1;
        end else begin
            e.lat = 2; e.data = 4'd0; e.err = 1'b1;
            tdr_out_i = 1'b1;
            repeat (4) @(negedge clk_i);
        end
        check("ready_before_rd", 32'(ready_o), 1);
        e.acc = cyc;
        q.push_back(e);
        rd_req_i = 1'b1;
        @(negedge clk_i);
        rd_req_i = 1'b0;
        if (mode == 0) begin
            repeat (c - 2) @(negedge clk_i);
            tdr_out_i = 1'b1; tdr_carry_i = carry;
        end
        wait_done();
        tdr_out_i = 1'b0; tdr_carry_i = 1'b0;
        repeat (4) @(negedge clk_i);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state while rst_i is held.
        #12;
        check("rst_we0", 32'(tdr_we0_o), 0);
        check("rst_we1", 32'(tdr_we1_o), 0);
        check("rst_re", 32'(tdr_re_o), 0);
        check("rst_rstb", 32'(tdr_rstb_o), 0);
        check("rst_ready", 32'(ready_o), 1);
        check("rst_wr_done", 32'(wr_done_o), 0);
        check("rst_rd_valid", 32'(rd_valid_o), 0);
        check("rst_rd_data", 32'(rd_data_o), 0);
        check("rst_rd_err", 32'(rd_err_o), 0);
        check("rst_rd_carry", 32'(rd_carry_o), 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        check("rstb_after_release", 32'(tdr_rstb_o), 1);
        check("ready_after_release", 32'(ready_o), 1);
        repeat (2) @(negedge clk_i);

        // Writes: V=5, V=0, and a simultaneous write+read where the read is dropped.
        do_write(5, 1'b0, 1'b1);
        do_write(0, 1'b0, 1'b1);
        do_write(7, 1'b1, 1'b1);
        repeat (80) @(negedge clk_i);

        // Reads: in range, underflow, overflow, timeout, stale.
        do_read(9, 1'b1, 0);
        do_read(3, 1'b0, 0);
        do_read(25, 1'b1, 0);
        do_read(12, 1'b0, 0);
        do_read(0, 1'b0, 1);
        do_read(0, 1'b0, 2);

        // Reset during the gap of a V=9 write aborts it without a done pulse.
        do_write(9, 1'b0, 1'b0);
        repeat (6) @(negedge clk_i);
        check("pre_abort_rstb", 32'(tdr_rstb_o), 1);
        check("pre_abort_busy", 32'(ready_o), 0);
        #2 rst_i = 1'b1;
        #1;
        check("abort_we0", 32'(tdr_we0_o), 0);
        check("abort_we1", 32'(tdr_we1_o), 0);
        check("abort_rstb", 32'(tdr_rstb_o), 0);
        check("abort_ready", 32'(ready_o), 1);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        repeat (20) @(negedge clk_i);
        do_write(3, 1'b0, 1'b1);

        check("queue_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
